multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the multi-cycle MIPS datapath: fetch, decode, execute, memory and writeback.
- Drives every datapath select/enable from the latched instruction and the ALU zero/overflow flags.
- Stalls on MIO_ready for all memory phases.
- Handles the CP0 interrupt entry (EPC save, vector fetch through memory) and eret.

Parameters:
- VEC_EN, 1, 1 = interrupt entry enabled; 0 = int_req ignored.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- inst  in  32  IR contents; opcode [31:26], funct [5:0], rs [25:21]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU overflow flag
- MIO_ready  in  1  memory access done this cycle
- int_req  in  1  level interrupt request, qualified by CP0
- IorD  out  1  0 = PC address, 1 = ALU_out address
- IRWrite  out  1  latch instruction
- mem_r / mem_w  out  1 each  memory read / write strobes
- RegDst  out  2  0 = rt, 1 = rd, 2 = $ra
- RegWrite  out  1  register file write enable
- MemtoReg  out  2  0 = ALU_out, 1 = MDR, 2 = lui, 3 = PC
- ALUSrcA  out  2  0 = PC, 1 = rs, 2 = imm, 3 = 0
- ALUSrcB  out  2  0 = rt, 1 = 4, 2 = imm, 3 = imm<<2
- PCSource  out  2  0 = ALUresult, 1 = ALU_out, 2 = jump target
- PCWrite, PCWriteCond, Branch  out  1 each  Branch = 1 taken on zero, 0 taken on ~zero
- ALU_operation  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 XOR
- MDRSrc / Data_sel  out  2 each  0 = word, 1 = byte
- cp0_selwt  out  1  1 = write CP0_out into reg (mfc0)
- cp0_selpc  out  2  0 = normal, 1 = EPC, 2 = MDR
- cp0_selmem  out  1  1 = vector_addr
- epc_we, eret_pulse, ovf_err  out  1 each  one-cycle pulses
- state  out  5  current state for debug

Behaviour:
- Outputs are decoded combinationally from state and opcode only.
- Any signal not listed for a state is 0.
- reset: state = FETCH asynchronously. Outputs then equal the FETCH vector.
- FETCH: mem_r=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0, PCWrite=1.
  - Hold while MIO_ready=0; the datapath gates PC_enable with MIO_ready.
  - On MIO_ready: go to DECODE.
  - Interrupt check happens before the fetch: in FETCH entry, if int_req && VEC_EN, go to INT_SAVE without reading.
  - int_req is sampled only when the state is about to become FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=3, ADD (branch target into ALU_out). Dispatch on opcode:
  - 000000 → R_EXE; funct 001000 (jr) → JR.
  - 100011 / 100000 / 101011 / 101000 (lw / lb / sw / sb) → MEM_ADDR.
  - 000100 / 000101 (beq / bne) → BRANCH.
  - 000010 → JUMP; 000011 → JAL.
  - 001000 / 001100 / 001101 / 001010 / 001110 (addi / andi / ori / slti / xori) → I_EXE.
  - 001111 → LUI.
  - 010000 with rs=10000, funct 011000 → ERET; rs=00000 (mfc0) → MFC0.
  - Anything else → FETCH (NOP).
- R_EXE: ALUSrcA=1, ALUSrcB=0.
  - funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
  - Next state R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
  - If overflow was latched in R_EXE for add/sub: RegWrite=0 and ovf_err=1.
- I_EXE: ALUSrcA=1, ALUSrcB=2, op per opcode; then I_WB.
- I_WB: RegDst=0, RegWrite=1, same overflow suppression for addi.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ADD. Loads → MEM_RD; stores → MEM_WR.
- MEM_RD: mem_r=1, IorD=1. Hold until MIO_ready, then MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1; MDRSrc=1 for lb, else 0.
- MEM_WR: mem_w=1, IorD=1, Data_sel=1 for sb, else 0. Hold until MIO_ready, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, PCWriteCond=1, PCSource=1, Branch=(opcode==beq).
- JUMP: PCSource=2, PCWrite=1.
- JAL: as JUMP plus RegDst=2, MemtoReg=3, RegWrite=1.
  - PC_Current is already PC+4, so $ra receives PC+4.
- JR: ALUSrcA=1, ALUSrcB=0 with ALU_operation OR, so A|rt; rt must be $0, so result = rs.
  - Also PCSource=0, PCWrite=1.
- LUI: RegDst=0, MemtoReg=2, RegWrite=1.
- MFC0: RegDst=0, cp0_selwt=1, RegWrite=1.
- ERET: cp0_selpc=1, PCWrite=1, eret_pulse=1.
- INT_SAVE: epc_we=1 (EPC ← PC_Current), then INT_VEC.
- INT_VEC: cp0_selmem=1, mem_r=1. Hold until MIO_ready, then INT_JMP.
- INT_JMP: cp0_selpc=2, MDRSrc=0, PCWrite=1, then FETCH.
  - int_req is ignored in this transition to guarantee one instruction of progress.
- Every non-memory state lasts exactly 1 cycle.
- Latencies: R/I-type 4 cycles, lw 5, sw 4, branch/jump 3, interrupt entry 3 + waits.
- reset mid-instruction: abort immediately; no writes complete after reset deasserts.

Test Plan:
- Reset, then release with MIO_ready=1 → state=FETCH, PCWrite=1, ALUSrcB=1, mem_r=1 in the first cycle.
- add $3,$1,$2 (0x00221820) → FETCH, DECODE, R_EXE (ALU_operation=0010), R_WB (RegDst=1, RegWrite=1); 4 cycles total.
- lw 0x8C220004 with MIO_ready low 3 cycles in MEM_RD → state held, mem_r=1, IorD=1; MEM_WB RegWrite=1, MemtoReg=1.
- beq (0x10220003) with zero=1 and bne with zero=0 → PCWriteCond=1, PCSource=1; Branch=1 and 0 respectively.
- jal 0x0C000010 → RegDst=2, MemtoReg=3, PCSource=2, RegWrite=1 in JAL.
- int_req=1 at instruction boundary → INT_SAVE epc_we, INT_VEC cp0_selmem=1, INT_JMP cp0_selpc=2.
  - Then eret (0x42000018) → cp0_selpc=1, eret_pulse=1.
  - Also: add with overflow=1 → RegWrite=0 and ovf_err=1 in R_WB.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath.
// It covers fetch, decode, execute, memory and writeback, plus CP0 interrupt entry and eret.
module multicycle_ctrl #(
    parameter bit VEC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic        overflow,
    input  logic        MIO_ready,
    input  logic        int_req,
    output logic        IorD,
    output logic        IRWrite,
    output logic        mem_r,
    output logic        mem_w,
    output logic [1:0]  RegDst,
    output logic        RegWrite,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic [3:0]  ALU_operation,
    output logic [1:0]  MDRSrc,
    output logic [1:0]  Data_sel,
    output logic        cp0_selwt,
    output logic [1:0]  cp0_selpc,
    output logic        cp0_selmem,
    output logic        epc_we,
    output logic        eret_pulse,
    output logic        ovf_err,
    output logic [4:0]  state
);

    typedef enum logic [4:0] {
        FETCH, DECODE, R_EXE, R_WB, I_EXE, I_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        BRANCH, JUMP, JAL, JR, LUI, MFC0, ERET, INT_SAVE, INT_VEC, INT_JMP
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                           ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100,
                           ALU_XOR = 4'b1101;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011, OP_LB   = 6'b100000,
                           OP_SW    = 6'b101011, OP_SB   = 6'b101000, OP_BEQ  = 6'b000100,
                           OP_BNE   = 6'b000101, OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                           OP_ADDI  = 6'b001000, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101,
                           OP_SLTI  = 6'b001010, OP_XORI = 6'b001110, OP_LUI  = 6'b001111,
                           OP_COP0  = 6'b010000;

    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                           F_OR  = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111,
                           F_SLT = 6'b101010, F_JR  = 6'b001000, F_ERET = 6'b011000;

    state_t     cur, nxt, fetch_next;
    logic       ovf_q;
    logic [5:0] opcode, funct;
    logic [4:0] rs;
    logic       unused_inputs;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];
    assign rs     = inst[25:21];
    assign state  = cur;

    // Branch resolution happens in the datapath, so zero and the rt/rd/shamt fields are not needed here.
    assign unused_inputs = ^{zero, inst[20:6]};

    // Every path back to FETCH is the instruction boundary where a pending interrupt is taken.
    assign fetch_next = (int_req && VEC_EN) ? INT_SAVE : FETCH;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    // Overflow is captured during execute so writeback can suppress the register write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               ovf_q <= 1'b0;
        else if (cur == R_EXE)   ovf_q <= overflow && (funct == F_ADD || funct == F_SUB);
        else if (cur == I_EXE)   ovf_q <= overflow && (opcode == OP_ADDI);
    end

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:    if (MIO_ready) nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:                     nxt = (funct == F_JR) ? JR : R_EXE;
                    OP_LW, OP_LB, OP_SW, OP_SB:   nxt = MEM_ADDR;
                    OP_BEQ, OP_BNE:               nxt = BRANCH;
                    OP_J:                         nxt = JUMP;
                    OP_JAL:                       nxt = JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI: nxt = I_EXE;
                    OP_LUI:                       nxt = LUI;
                    OP_COP0: begin
                        if (rs == 5'b10000 && funct == F_ERET) nxt = ERET;
                        else if (rs == 5'b00000)               nxt = MFC0;
                        else                                   nxt = fetch_next;
                    end
                    default:                      nxt = fetch_next;
                endcase
            end
            R_EXE:    nxt = R_WB;
            I_EXE:    nxt = I_WB;
            MEM_ADDR: nxt = (opcode == OP_LW || opcode == OP_LB) ? MEM_RD : MEM_WR;
            MEM_RD:   if (MIO_ready) nxt = MEM_WB;
            MEM_WR:   if (MIO_ready) nxt = fetch_next;
            R_WB, I_WB, MEM_WB, BRANCH, JUMP, JAL, JR, LUI, MFC0, ERET: nxt = fetch_next;
            INT_SAVE: nxt = INT_VEC;
            INT_VEC:  if (MIO_ready) nxt = INT_JMP;
            INT_JMP:  nxt = FETCH;
            default:  nxt = FETCH;
        endcase
    end

    always_comb begin
        IorD = 1'b0; IRWrite = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
        RegDst = 2'd0; RegWrite = 1'b0; MemtoReg = 2'd0;
        ALUSrcA = 2'd0; ALUSrcB = 2'd0; PCSource = 2'd0;
        PCWrite = 1'b0; PCWriteCond = 1'b0; Branch = 1'b0;
        ALU_operation = ALU_AND; MDRSrc = 2'd0; Data_sel = 2'd0;
        cp0_selwt = 1'b0; cp0_selpc = 2'd0; cp0_selmem = 1'b0;
        epc_we = 1'b0; eret_pulse = 1'b0; ovf_err = 1'b0;
        case (cur)
            FETCH: begin
                mem_r = 1'b1; IRWrite = 1'b1; ALUSrcB = 2'd1;
                ALU_operation = ALU_ADD; PCWrite = 1'b1;
            end
            DECODE: begin
                ALUSrcB = 2'd3; ALU_operation = ALU_ADD;
            end
            R_EXE: begin
                ALUSrcA = 2'd1;
                case (funct)
                    F_SUB:   ALU_operation = ALU_SUB;
                    F_AND:   ALU_operation = ALU_AND;
                    F_OR:    ALU_operation = ALU_OR;
                    F_XOR:   ALU_operation = ALU_XOR;
                    F_NOR:   ALU_operation = ALU_NOR;
                    F_SLT:   ALU_operation = ALU_SLT;
                    default: ALU_operation = ALU_ADD;
                endcase
            end
            R_WB: begin
                RegDst = 2'd1; RegWrite = !ovf_q; ovf_err = ovf_q;
            end
            I_EXE: begin
                ALUSrcA = 2'd1; ALUSrcB = 2'd2;
                case (opcode)
                    OP_ANDI: ALU_operation = ALU_AND;
                    OP_ORI:  ALU_operation = ALU_OR;
                    OP_SLTI: ALU_operation = ALU_SLT;
                    OP_XORI: ALU_operation = ALU_XOR;
                    default: ALU_operation = ALU_ADD;
                endcase
            end
            I_WB: begin
                RegWrite = !ovf_q; ovf_err = ovf_q;
            end
            MEM_ADDR: begin
                ALUSrcA = 2'd1; ALUSrcB = 2'd2; ALU_operation = ALU_ADD;
            end
            MEM_RD: begin
                mem_r = 1'b1; IorD = 1'b1;
            end
            MEM_WB: begin
                MemtoReg = 2'd1; RegWrite = 1'b1;
                MDRSrc = (opcode == OP_LB) ? 2'd1 : 2'd0;
            end
            MEM_WR: begin
                mem_w = 1'b1; IorD = 1'b1;
                Data_sel = (opcode == OP_SB) ? 2'd1 : 2'd0;
            end
            BRANCH: begin
                ALUSrcA = 2'd1; ALU_operation = ALU_SUB; PCWriteCond = 1'b1;
                PCSource = 2'd1; Branch = (opcode == OP_BEQ);
            end
            JUMP: begin
                PCSource = 2'd2; PCWrite = 1'b1;
            end
            JAL: begin
                PCSource = 2'd2; PCWrite = 1'b1;
                RegDst = 2'd2; MemtoReg = 2'd3; RegWrite = 1'b1;
            end
            // rt is required to be $0, so OR passes rs through as the jump target.
            JR: begin
                ALUSrcA = 2'd1; ALU_operation = ALU_OR; PCWrite = 1'b1;
            end
            LUI: begin
                MemtoReg = 2'd2; RegWrite = 1'b1;
            end
            MFC0: begin
                cp0_selwt = 1'b1; RegWrite = 1'b1;
            end
            ERET: begin
                cp0_selpc = 2'd1; PCWrite = 1'b1; eret_pulse = 1'b1;
            end
            INT_SAVE: epc_we = 1'b1;
            INT_VEC: begin
                cp0_selmem = 1'b1; mem_r = 1'b1;
            end
            INT_JMP: begin
                cp0_selpc = 2'd2; PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
